// File: rtl/vm_pkg.sv
// Shared types and constants for the change-giving vending controller.
// Coin values are in cents; chg_coin encodings match the hopper interface.
package vm_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'b001,
    VEND    = 3'b010,
    CHANGE  = 3'b100
  } state_t;

  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

  localparam logic [1:0] CHG_NONE   = 2'b00;
  localparam logic [1:0] CHG_NICKEL = 2'b01;
  localparam logic [1:0] CHG_DIME   = 2'b10;

  // Value of a single coin pulse; callers guarantee at most one input is high.
  function automatic int coin_value(input logic n, input logic d, input logic q);
    if (n) return NICKEL_C;
    if (d) return DIME_C;
    if (q) return QUARTER_C;
    return 0;
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Change-coin selection and hopper handshake. Purely combinational over the
// registered credit, so chg_valid/chg_coin never depend on chg_ready.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                start,
  input  logic [CREDIT_W-1:0] load_val,
  input  logic                chg_ready,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] credit_next,
  output logic                done
);

  logic [CREDIT_W-1:0] amount;

  // start is held high for every cycle the controller sits in CHANGE.
  always_comb begin
    chg_valid   = 1'b0;
    chg_coin    = CHG_NONE;
    credit_next = load_val;
    done        = 1'b0;
    amount      = '0;
    if (start) begin
      chg_valid = 1'b1;
      if (load_val >= CREDIT_W'(DIME_C)) begin
        chg_coin = CHG_DIME;
        amount   = CREDIT_W'(DIME_C);
      end else begin
        chg_coin = CHG_NICKEL;
        amount   = CREDIT_W'(NICKEL_C);
      end
      if (chg_ready) begin
        credit_next = load_val - amount;
        done        = (credit_next == '0);
      end
    end
  end

endmodule

// File: rtl/vending_machine_change.sv
// Moore vending controller: collects N/D/Q against PRICE, strobes open for one
// cycle, then pays surplus credit out as dimes/nickels through the dispenser.
module vending_machine_change
  import vm_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                cancel,
  output logic                open,
  output logic                coin_reject,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (PRICE < 5 || PRICE > 95 || (PRICE % 5) != 0) begin : g_bad_price
    $error("PRICE must be a multiple of 5 in 5..95");
  end
  if (PRICE + 20 > (1 << CREDIT_W) - 1) begin : g_bad_width
    $error("CREDIT_W too narrow to hold PRICE+20");
  end

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                reject_reg, reject_next;

  logic [1:0]          coin_cnt;
  logic                any_coin;
  logic [CREDIT_W:0]   sum;
  logic                in_change;
  logic [CREDIT_W-1:0] disp_credit;
  logic                disp_done;

  assign coin_cnt  = 2'(N) + 2'(D) + 2'(Q);
  assign any_coin  = N | D | Q;
  assign sum       = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_value(N, D, Q));
  assign in_change = (state_reg == CHANGE);

  vm_change_dispenser #(
    .CREDIT_W(CREDIT_W)
  ) u_disp (
    .start      (in_change),
    .load_val   (credit_reg),
    .chg_ready  (chg_ready),
    .chg_valid  (chg_valid),
    .chg_coin   (chg_coin),
    .credit_next(disp_credit),
    .done       (disp_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= COLLECT;
      credit_reg <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      reject_reg <= reject_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    reject_next = 1'b0;
    case (state_reg)
      COLLECT: begin
        // cancel outranks coins; any coin alongside it goes back to the customer
        if (cancel) begin
          reject_next = any_coin;
          if (credit_reg != '0) state_next = CHANGE;
        end else if (coin_cnt > 2'd1) begin
          reject_next = 1'b1;
        end else if (coin_cnt == 2'd1) begin
          if (sum >= (CREDIT_W+1)'(PRICE)) begin
            credit_next = CREDIT_W'(sum - (CREDIT_W+1)'(PRICE));
            state_next  = VEND;
          end else begin
            credit_next = CREDIT_W'(sum);
          end
        end
      end
      VEND: begin
        reject_next = any_coin;
        state_next  = (credit_reg != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_next = any_coin;
        credit_next = disp_credit;
        if (disp_done) state_next = COLLECT;
      end
      default: begin
        state_next  = COLLECT;
        credit_next = '0;
      end
    endcase
  end

  assign open        = (state_reg == VEND);
  assign busy        = (state_reg == VEND) || (state_reg == CHANGE);
  assign coin_reject = reject_reg;
  assign credit      = credit_reg;

endmodule

// File: tb/tb_vending_machine_change.sv
// Scoreboard bench: expected open/reject/change events are queued as stimulus
// is driven and popped by a negedge monitor; direct checks cover credit/state.
module tb_vending_machine_change;

  localparam int EV_NICKEL = 1;
  localparam int EV_DIME   = 2;
  localparam int EV_OPEN   = 16;
  localparam int EV_REJ    = 32;

  logic       clk = 1'b0;
  logic       rstn, n, d, q, cancel, chg_ready;
  logic       open, coin_reject, chg_valid, busy;
  logic [1:0] chg_coin;
  logic [6:0] credit;

  logic       rstn2, n2, d2, q2, cancel2, chg_ready2;
  logic       open2, coin_reject2, chg_valid2, busy2;
  logic [1:0] chg_coin2;
  logic [6:0] credit2;

  int n_checks = 0;
  int n_errors = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  vending_machine_change #(.PRICE(15), .CREDIT_W(7)) dut (
    .clk(clk), .rstn(rstn), .N(n), .D(d), .Q(q), .cancel(cancel),
    .open(open), .coin_reject(coin_reject), .chg_valid(chg_valid),
    .chg_coin(chg_coin), .chg_ready(chg_ready), .credit(credit), .busy(busy)
  );

  vending_machine_change #(.PRICE(40), .CREDIT_W(7)) dut40 (
    .clk(clk), .rstn(rstn2), .N(n2), .D(d2), .Q(q2), .cancel(cancel2),
    .open(open2), .coin_reject(coin_reject2), .chg_valid(chg_valid2),
    .chg_coin(chg_coin2), .chg_ready(chg_ready2), .credit(credit2), .busy(busy2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop(input int idx, input int code);
    int exp_code;
    if (idx == 0) begin
      if (q0.size() == 0) check_eq("sb0_unexpected", code, 0);
      else begin
        exp_code = q0.pop_front();
        check_eq("sb0_event", code, exp_code);
      end
    end else begin
      if (q1.size() == 0) check_eq("sb40_unexpected", code, 0);
      else begin
        exp_code = q1.pop_front();
        check_eq("sb40_event", code, exp_code);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (open) sb_pop(0, EV_OPEN);
      if (coin_reject) sb_pop(0, EV_REJ);
      if (chg_valid && chg_ready) sb_pop(0, int'(chg_coin));
    end
    if (rstn2) begin
      if (open2) sb_pop(1, EV_OPEN);
      if (coin_reject2) sb_pop(1, EV_REJ);
      if (chg_valid2 && chg_ready2) sb_pop(1, int'(chg_coin2));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic pn, input logic pd, input logic pq, input logic pc);
    n = pn; d = pd; q = pq; cancel = pc;
    $display("txn dut15: N=%0b D=%0b Q=%0b cancel=%0b", pn, pd, pq, pc);
    tick;
    n = 1'b0; d = 1'b0; q = 1'b0; cancel = 1'b0;
  endtask

  task automatic pulse_q40;
    q2 = 1'b1;
    $display("txn dut40: Q");
    tick;
    q2 = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; n = 1'b0; d = 1'b0; q = 1'b0; cancel = 1'b0; chg_ready = 1'b0;
    rstn2 = 1'b0; n2 = 1'b0; d2 = 1'b0; q2 = 1'b0; cancel2 = 1'b0; chg_ready2 = 1'b0;
    repeat (2) tick;
    check_eq("rst_open", int'(open), 0);
    check_eq("rst_reject", int'(coin_reject), 0);
    check_eq("rst_valid", int'(chg_valid), 0);
    check_eq("rst_coin", int'(chg_coin), 0);
    check_eq("rst_credit", int'(credit), 0);
    check_eq("rst_busy", int'(busy), 0);
    rstn = 1'b1; rstn2 = 1'b1;
    tick;

    // exact price from three nickels
    pulse(1, 0, 0, 0);
    check_eq("t1_credit5", int'(credit), 5);
    pulse(1, 0, 0, 0);
    check_eq("t1_credit10", int'(credit), 10);
    q0.push_back(EV_OPEN);
    pulse(1, 0, 0, 0);
    check_eq("t1_open", int'(open), 1);
    check_eq("t1_credit0", int'(credit), 0);
    tick;
    check_eq("t1_open_low", int'(open), 0);
    check_eq("t1_no_valid", int'(chg_valid), 0);

    // quarter: one dime back
    chg_ready = 1'b1;
    q0.push_back(EV_OPEN);
    q0.push_back(EV_DIME);
    pulse(0, 0, 1, 0);
    check_eq("t2_credit10", int'(credit), 10);
    tick;
    check_eq("t2_valid", int'(chg_valid), 1);
    check_eq("t2_coin", int'(chg_coin), 2);
    tick;
    check_eq("t2_credit0", int'(credit), 0);
    check_eq("t2_valid_low", int'(chg_valid), 0);
    chg_ready = 1'b0;

    // D then Q, hopper stalls three cycles
    pulse(0, 1, 0, 0);
    check_eq("t3_credit10", int'(credit), 10);
    q0.push_back(EV_OPEN);
    pulse(0, 0, 1, 0);
    check_eq("t3_credit20", int'(credit), 20);
    tick;
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_hold_valid", int'(chg_valid), 1);
      check_eq("t3_hold_coin", int'(chg_coin), 2);
      check_eq("t3_hold_credit", int'(credit), 20);
      check_eq("t3_hold_busy", int'(busy), 1);
      tick;
    end
    q0.push_back(EV_DIME);
    q0.push_back(EV_DIME);
    chg_ready = 1'b1;
    tick;
    check_eq("t3_credit10b", int'(credit), 10);
    check_eq("t3_coin2", int'(chg_coin), 2);
    tick;
    check_eq("t3_credit0", int'(credit), 0);
    check_eq("t3_valid_low", int'(chg_valid), 0);
    check_eq("t3_busy_low", int'(busy), 0);
    chg_ready = 1'b0;

    // cancel with a nickel in the same cycle
    chg_ready = 1'b1;
    pulse(0, 1, 0, 0);
    q0.push_back(EV_REJ);
    q0.push_back(EV_DIME);
    pulse(1, 0, 0, 1);
    check_eq("t4_reject", int'(coin_reject), 1);
    check_eq("t4_credit10", int'(credit), 10);
    check_eq("t4_valid", int'(chg_valid), 1);
    tick;
    check_eq("t4_credit0", int'(credit), 0);
    chg_ready = 1'b0;

    // two coins at once, then a quarter during VEND
    q0.push_back(EV_REJ);
    pulse(1, 1, 0, 0);
    check_eq("t5_reject", int'(coin_reject), 1);
    check_eq("t5_credit0", int'(credit), 0);
    pulse(1, 0, 0, 0);
    q0.push_back(EV_OPEN);
    pulse(0, 1, 0, 0);
    check_eq("t5_open", int'(open), 1);
    q0.push_back(EV_REJ);
    pulse(0, 0, 1, 0);
    check_eq("t5_vend_reject", int'(coin_reject), 1);
    check_eq("t5_vend_credit", int'(credit), 0);
    check_eq("t5_busy", int'(busy), 0);
    pulse(0, 0, 0, 1);
    check_eq("t5_cancel0_busy", int'(busy), 0);
    check_eq("t5_cancel0_valid", int'(chg_valid), 0);

    // PRICE=40 instance, async reset during CHANGE
    pulse_q40;
    check_eq("t6_credit25", int'(credit2), 25);
    q1.push_back(EV_OPEN);
    pulse_q40;
    check_eq("t6_open", int'(open2), 1);
    check_eq("t6_credit10", int'(credit2), 10);
    tick;
    check_eq("t6_valid", int'(chg_valid2), 1);
    check_eq("t6_coin", int'(chg_coin2), 2);
    #2;
    rstn2 = 1'b0;
    #1;
    check_eq("t6_rst_valid", int'(chg_valid2), 0);
    check_eq("t6_rst_credit", int'(credit2), 0);
    check_eq("t6_rst_open", int'(open2), 0);
    check_eq("t6_rst_busy", int'(busy2), 0);
    #3;
    rstn2 = 1'b1;
    tick;
    check_eq("t6_post_busy", int'(busy2), 0);
    pulse_q40;
    check_eq("t6_post_credit25", int'(credit2), 25);

    repeat (3) tick;
    check_eq("q0_drained", q0.size(), 0);
    check_eq("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
